// File: rtl/nand_rst_sequencer_pkg.sv
// ============================================================================
// nand_rst_pkg : shared FSM state encoding and elaboration helpers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package nand_rst_pkg;

  localparam int SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    WAIT_RDY = 2'd0,
    HOLD     = 2'd1,
    RELEASE  = 2'd2,
    RUN      = 2'd3
  } seq_state_t;

  // Ceiling log2 for sizing counters and indices at elaboration time.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nand_rst_sequencer_if.sv
// ============================================================================
// nand_rst_sequencer_if : readiness/soft-reset inputs and channel reset outputs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface nand_rst_sequencer_if #(
  parameter int NUM_RDY  = 2,
  parameter int NUM_CHAN = 4
);

  logic [NUM_RDY-1:0]  rdy_in;
  logic [NUM_CHAN-1:0] soft_rst_req;
  logic [NUM_CHAN-1:0] chan_rstn;
  logic                all_rdy;
  logic                timeout_err;
  logic [1:0]          seq_state;

  modport master (
    output rdy_in,
    output soft_rst_req,
    input  chan_rstn,
    input  all_rdy,
    input  timeout_err,
    input  seq_state
  );

  modport slave (
    input  rdy_in,
    input  soft_rst_req,
    output chan_rstn,
    output all_rdy,
    output timeout_err,
    output seq_state
  );

endinterface

`default_nettype wire

// File: rtl/nand_rst_stretch.sv
// ============================================================================
// nand_rst_stretch : one channel reset, released by the sequencer and
//                    pulsed low for HOLD_CYCLES on a soft-reset request
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module nand_rst_stretch #(
  parameter int HOLD_CYCLES = 25,
  parameter int CNT_W       = 21
) (
  input  wire logic clk0,
  input  wire logic rstn0,
  input  wire logic i_release,
  input  wire logic i_soft_req,
  input  wire logic i_abort,
  output logic      o_rstn
);

  logic             r_rstn;
  logic [CNT_W-1:0] r_cnt;

  // A non-zero counter means a soft reset is in progress; requests arriving
  // then, or before the channel was released, are dropped.
  always_ff @(posedge clk0) begin
    if (!rstn0) begin
      r_rstn <= 1'b0;
      r_cnt  <= '0;
    end else if (i_abort) begin
      r_rstn <= 1'b0;
      r_cnt  <= '0;
    end else if (i_release) begin
      r_rstn <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_rstn <= 1'b1;
      end
    end else if (i_soft_req && r_rstn) begin
      r_rstn <= 1'b0;
      r_cnt  <= CNT_W'(HOLD_CYCLES);
    end
  end

  assign o_rstn = r_rstn;

endmodule

`default_nettype wire

// File: rtl/nand_rst_sequencer.sv
// ============================================================================
// nand_rst_sequencer : qualifies readiness inputs and releases per-channel
//                      NAND bus resets one by one with a startup watchdog
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module nand_rst_sequencer
  import nand_rst_pkg::*;
#(
  parameter int NUM_RDY        = 2,
  parameter int NUM_CHAN       = 4,
  parameter int HOLD_CYCLES    = 25,
  parameter int STAGGER_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input wire logic               clk0,
  input wire logic               rstn0,
  nand_rst_sequencer_if.slave    bus
);

  localparam int               IDX_W        = (NUM_CHAN > 1) ? clog2(NUM_CHAN) : 1;
  localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(NUM_CHAN - 1);

  logic [NUM_RDY-1:0]  r_sync1;
  logic [NUM_RDY-1:0]  r_sync2;
  logic                w_rdy_s;

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [CNT_W-1:0]    r_hold_cnt;
  logic [CNT_W-1:0]    w_hold_nxt;
  logic [CNT_W-1:0]    r_stag_cnt;
  logic [CNT_W-1:0]    w_stag_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CNT_W-1:0]    r_wd;
  logic [CNT_W-1:0]    w_wd_nxt;
  logic                r_terr;
  logic                w_terr_nxt;

  logic [NUM_CHAN-1:0] w_rel;
  logic                w_abort;
  logic [NUM_CHAN-1:0] w_chan_rstn;

  always_ff @(posedge clk0) begin
    if (!rstn0) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.rdy_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rdy_s = &r_sync2;

  always_ff @(posedge clk0) begin
    if (!rstn0) begin
      r_state    <= WAIT_RDY;
      r_hold_cnt <= '0;
      r_stag_cnt <= '0;
      r_idx      <= '0;
      r_wd       <= '0;
      r_terr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_stag_cnt <= w_stag_nxt;
      r_idx      <= w_idx_nxt;
      r_wd       <= w_wd_nxt;
      r_terr     <= w_terr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_stag_nxt  = r_stag_cnt;
    w_idx_nxt   = r_idx;
    w_wd_nxt    = '0;
    w_terr_nxt  = r_terr;
    w_rel       = '0;

    case (r_state)
      WAIT_RDY: begin
        w_hold_nxt = '0;
        w_stag_nxt = '0;
        w_idx_nxt  = '0;
        if (w_rdy_s) begin
          w_state_nxt = HOLD;
        end else begin
          // Watchdog saturates at the limit so the flag stays put until rstn0.
          w_wd_nxt = (r_wd == C_TIMEOUT) ? r_wd : r_wd + CNT_W'(1);
          if (w_wd_nxt == C_TIMEOUT) begin
            w_terr_nxt = 1'b1;
          end
        end
      end

      HOLD: begin
        if (!w_rdy_s) begin
          w_state_nxt = WAIT_RDY;
        end else if (r_hold_cnt == C_HOLD_LAST) begin
          w_rel[0] = 1'b1;
          if (NUM_CHAN == 1) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = RELEASE;
            w_stag_nxt  = '0;
            w_idx_nxt   = IDX_W'(1);
          end
        end else begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (!w_rdy_s) begin
          w_state_nxt = WAIT_RDY;
        end else if (r_stag_cnt == C_STAG_LAST) begin
          w_rel      = NUM_CHAN'(1) << r_idx;
          w_stag_nxt = '0;
          w_idx_nxt  = r_idx + IDX_W'(1);
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = RUN;
          end
        end else begin
          w_stag_nxt = r_stag_cnt + CNT_W'(1);
        end
      end

      RUN: begin
        if (!w_rdy_s) begin
          w_state_nxt = WAIT_RDY;
        end
      end

      default: begin
        w_state_nxt = WAIT_RDY;
      end
    endcase
  end

  // Holding every channel in abort while idle keeps stale soft-reset counts
  // from surviving a trip back through WAIT_RDY.
  assign w_abort = (r_state == WAIT_RDY) || !w_rdy_s;

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
    nand_rst_stretch #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_stretch (
      .clk0       (clk0),
      .rstn0      (rstn0),
      .i_release  (w_rel[gi]),
      .i_soft_req (bus.soft_rst_req[gi]),
      .i_abort    (w_abort),
      .o_rstn     (w_chan_rstn[gi])
    );
  end

  assign bus.chan_rstn   = w_chan_rstn;
  assign bus.all_rdy     = (r_state == RUN) && (&w_chan_rstn);
  assign bus.timeout_err = r_terr;
  assign bus.seq_state   = r_state;

endmodule

`default_nettype wire
